// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA 640x480@60 Hz timing generator.
//
// Divides the system clock by two into a pixel tick, runs the horizontal and
// vertical pixel counters, and produces registered active-low syncs, a
// visible-area flag, a one-cycle frame-start pulse and blanked RGB.
//
// Ports:
//   Clock             in   system clock (50 MHz), rising edge
//   Resetn            in   asynchronous active-low reset
//   dR, dG, dB        in   colour from draw logic, combinational on counters
//   HCounter[9:0]     out  current pixel column, 0..H_TOTAL-1
//   VCounter[9:0]     out  current line, 0..V_TOTAL-1
//   PixelTick         out  high every second Clock; counters advance on it
//   HSync, VSync      out  registered active-low syncs
//   VideoOn           out  registered visible-area flag
//   FrameStart        out  one-Clock pulse on wrap to (0,0)
//   VGA_R/G/B         out  registered colour, forced to 0 when blanked
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       dR,
    input  logic       dG,
    input  logic       dB,
    output logic [9:0] HCounter,
    output logic [9:0] VCounter,
    output logic       PixelTick,
    output logic       HSync,
    output logic       VSync,
    output logic       VideoOn,
    output logic       FrameStart,
    output logic       VGA_R,
    output logic       VGA_G,
    output logic       VGA_B
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       phase_q, phase_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;
    logic       red_q, red_d;
    logic       green_q, green_d;
    logic       blue_q, blue_d;

    always_comb begin
        phase_d       = ~phase_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = 1'b0;

        if (phase_q) begin
            // ">=" rather than "==" so any out-of-range value recovers to 0.
            if (h_cnt_q >= H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q >= V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
                frame_start_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
                if (v_cnt_q > V_LAST) begin
                    v_cnt_d = '0;
                end
            end
        end

        // Decode uses the counters as held this cycle, so outputs lag by one Clock.
        hsync_d    = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q <= H_SYNC_END));
        vsync_d    = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q <= V_SYNC_END));
        video_on_d = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
        red_d      = dR & video_on_d;
        green_d    = dG & video_on_d;
        blue_d     = dB & video_on_d;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            phase_q       <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= 1'b0;
            green_q       <= 1'b0;
            blue_q        <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign HCounter   = h_cnt_q;
    assign VCounter   = v_cnt_q;
    assign PixelTick  = phase_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign VideoOn    = video_on_q;
    assign FrameStart = frame_start_q;
    assign VGA_R      = red_q;
    assign VGA_G      = green_q;
    assign VGA_B      = blue_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Instance "dut_a" uses full 640x480 timing for the
// line-level checks; "dut_b" uses a shrunken 16x10 raster so frame-level,
// blanking, handshake and mid-sync reset behaviour fit in a short run.
// dut_b geometry: H visible 8, H sync cols 10..13, H_TOTAL 16;
//                 V visible 4, V sync lines 6..7, V_TOTAL 10.
// Frame = 16*10*2 = 320 Clocks.
module tb_vga_sync_gen;

    logic       clk;
    logic       rst_a, rst_b;
    logic       dr_a, dg_a, db_a;
    logic       dr_b, dg_b, db_b;
    logic       mode_b;
    logic [9:0] hc_a, vc_a, hc_b, vc_b;
    logic       pt_a, hs_a, vs_a, von_a, fs_a, r_a, g_a, b_a;
    logic       pt_b, hs_b, vs_b, von_b, fs_b, r_b, g_b, b_b;

    int tests_run;
    int tests_failed;

    vga_sync_gen dut_a (
        .Clock(clk), .Resetn(rst_a), .dR(dr_a), .dG(dg_a), .dB(db_a),
        .HCounter(hc_a), .VCounter(vc_a), .PixelTick(pt_a),
        .HSync(hs_a), .VSync(vs_a), .VideoOn(von_a), .FrameStart(fs_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_b (
        .Clock(clk), .Resetn(rst_b), .dR(dr_b), .dG(dg_b), .dB(db_b),
        .HCounter(hc_b), .VCounter(vc_b), .PixelTick(pt_b),
        .HSync(hs_b), .VSync(vs_b), .VideoOn(von_b), .FrameStart(fs_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
    );

    // Draw-module stand-in: green lit only on lines 2..7 once mode_b is set.
    assign dg_b = mode_b ? ((vc_b >= 10'd2) && (vc_b <= 10'd7)) : 1'b1;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int hs_low, fs_a_cnt;
    int vs_low, fs_hits, fs_first, fs_second, g_hi, g_bad, fs2;
    int found;

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        dr_a = 1'b1; dg_a = 1'b1; db_a = 1'b1;
        dr_b = 1'b1; db_b = 1'b1;
        mode_b = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a_hsync", hs_a, 1);
        check("rst_a_vsync", vs_a, 1);
        check("rst_a_videoon", von_a, 0);
        check("rst_a_framestart", fs_a, 0);
        check("rst_a_rgb", {r_a, g_a, b_a}, 0);
        check("rst_a_hcnt", hc_a, 0);
        check("rst_a_vcnt", vc_a, 0);
        check("rst_a_tick", pt_a, 0);
        check("rst_b_hsync", hs_b, 1);
        check("rst_b_rgb", {r_b, g_b, b_b}, 0);

        // ---------------- full-size instance: one line ----------------
        rst_a = 1'b1;
        check("a_tick_cycle1", pt_a, 0);
        hs_low = 0; fs_a_cnt = 0;
        for (int m = 1; m <= 1600; m++) begin
            @(negedge clk);
            if (!hs_a) hs_low++;
            if (fs_a) fs_a_cnt++;
            case (m)
                1:    begin check("a_tick_cycle2", pt_a, 1); check("a_h_e1", hc_a, 0); end
                2:    begin check("a_tick_cycle3", pt_a, 0); check("a_h_e2", hc_a, 1); end
                1278: check("a_h_639", hc_a, 639);
                1279: begin check("a_von_639", von_a, 1); check("a_rgb_639_0", {r_a, g_a, b_a}, 7); end
                1280: check("a_h_640", hc_a, 640);
                1281: begin check("a_von_640", von_a, 0); check("a_rgb_640_0", {r_a, g_a, b_a}, 0); end
                1312: begin check("a_h_656", hc_a, 656); check("a_hs_before", hs_a, 1); end
                1313: check("a_hs_fall", hs_a, 0);
                1504: begin check("a_h_752", hc_a, 752); check("a_hs_still_low", hs_a, 0); end
                1505: check("a_hs_rise", hs_a, 1);
                1598: begin check("a_h_799", hc_a, 799); check("a_v_line0", vc_a, 0); end
                1600: begin
                    check("a_h_wrap", hc_a, 0);
                    check("a_v_inc", vc_a, 1);
                    check("a_fs_line_wrap", fs_a, 0);
                end
                default: ;
            endcase
        end
        check("a_hsync_low_clocks", hs_low, 192);
        check("a_no_framestart", fs_a_cnt, 0);

        // ---------------- small instance: two frames ----------------
        rst_b = 1'b1;
        check("b_tick_cycle1", pt_b, 0);
        vs_low = 0; fs_hits = 0; fs_first = 0; fs_second = 0; g_hi = 0; g_bad = 0;
        for (int n = 1; n <= 660; n++) begin
            @(negedge clk);
            if (n <= 320 && !vs_b) vs_low++;
            if (fs_b) begin
                fs_hits++;
                if (fs_hits == 1) fs_first = n;
                if (fs_hits == 2) fs_second = n;
            end
            if (n > 320 && n <= 640) begin
                if (g_b) g_hi++;
                if (g_b && vc_b >= 10'd4) g_bad++;
            end
            case (n)
                16:  check("b_h_8", hc_b, 8);
                17:  check("b_rgb_8_0", {r_b, g_b, b_b}, 0);
                110: begin check("b_h_7", hc_b, 7); check("b_v_3", vc_b, 3); end
                111: begin check("b_rgb_7_3", {r_b, g_b, b_b}, 7); check("b_von_7_3", von_b, 1); end
                128: begin check("b_h_0_v4", hc_b, 0); check("b_v_4", vc_b, 4); end
                129: check("b_rgb_0_4", {r_b, g_b, b_b}, 0);
                192: begin check("b_v_6", vc_b, 6); check("b_vs_before", vs_b, 1); end
                193: check("b_vs_fall", vs_b, 0);
                256: begin check("b_v_8", vc_b, 8); check("b_vs_still_low", vs_b, 0); end
                257: check("b_vs_rise", vs_b, 1);
                318: begin check("b_h_15", hc_b, 15); check("b_v_9", vc_b, 9); end
                319: begin check("b_rgb_15_9", {r_b, g_b, b_b}, 0); check("b_fs_pre", fs_b, 0); end
                320: begin
                    check("b_h_wrap", hc_b, 0);
                    check("b_v_wrap", vc_b, 0);
                    check("b_fs_pulse", fs_b, 1);
                    mode_b = 1'b1;
                end
                321: check("b_fs_one_clock", fs_b, 0);
                353: check("b_g_line1", g_b, 0);
                385: check("b_g_line2", g_b, 1);
                481: check("b_g_line5", g_b, 0);
                default: ;
            endcase
        end
        check("b_fs_count", fs_hits, 2);
        check("b_fs_first", fs_first, 320);
        check("b_fs_period", fs_second - fs_first, 320);
        check("b_vsync_low_clocks", vs_low, 64);
        check("b_g_visible_clocks", g_hi, 32);
        check("b_g_blank_lines", g_bad, 0);

        // ---------------- mid-sync reset on small instance ----------------
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            @(negedge clk);
            if (hc_b == 10'd12 && vc_b == 10'd7) found = 1;
        end
        check("b_find_sync_point", found, 1);
        check("b_in_hsync", hs_b, 0);
        check("b_in_vsync", vs_b, 0);
        rst_b = 1'b0;
        #1;
        check("b_async_hsync", hs_b, 1);
        check("b_async_vsync", vs_b, 1);
        check("b_async_hcnt", hc_b, 0);
        check("b_async_vcnt", vc_b, 0);
        check("b_async_tick", pt_b, 0);
        check("b_async_videoon", von_b, 0);
        @(negedge clk);
        rst_b = 1'b1;
        fs2 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (fs_b) fs2++;
            case (n)
                1:  begin check("b_re_tick", pt_b, 1); check("b_re_h_e1", hc_b, 0); end
                2:  check("b_re_h_e2", hc_b, 1);
                32: begin check("b_re_h_wrap", hc_b, 0); check("b_re_v_1", vc_b, 1); end
                default: ;
            endcase
        end
        check("b_re_no_framestart", fs2, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
